// File: rtl/btn_event_conditioner.sv
// btn_event_conditioner
//   Front end for the character physics/FSM stage. Synchronises and debounces
//   the raw left/right/jump buttons, produces the game-tick strobe and latches
//   every debounced press/release edge into flags that are held for one full
//   tick period, so a short press is never lost by the slower character stage.
//
//   Ports
//     sys_clk, sys_rst_n          clock, async active-low reset (sync release)
//     left_btn/right_btn/jump_btn raw asynchronous buttons, active-high
//     tick                        one-cycle strobe every TICK_DIV cycles
//     *_level                     debounced levels, not tick-aligned
//     left_evt/right_evt/jump_evt press seen during the previous tick period
//     jump_rel_evt                jump release seen during the previous period
//
//   Optional feature: define BTN_AUTO_REPEAT_EN to make a held left/right
//   button re-raise its event every REPEAT_TICKS ticks. Jump never repeats.

// One debounce FSM. o_edge pulses for one cycle in the same cycle o_level
// changes; the caller splits it into press/release using the new level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_in,
   output logic o_level,
   output logic o_edge
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   // The IDLE/HELD cycle that spots the new value is the first stable sample,
   // so the wait states finish one count early to give exactly DEBOUNCE_CYCLES.
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_HELD, S_RELEASE_WAIT} state_t;

   state_t          r_state, w_state_nx;
   logic [CW-1:0]   r_cnt, w_cnt_nx;
   logic            r_edge, w_edge_nx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_edge  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_edge  <= w_edge_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_edge_nx  = 1'b0;
      case (r_state)
         S_IDLE:
            if (i_in) begin
               w_state_nx = S_PRESS_WAIT;
               w_cnt_nx   = '0;
            end
         S_PRESS_WAIT:
            if (!i_in) begin
               w_state_nx = S_IDLE;
            end else if (r_cnt == C_LAST) begin
               w_state_nx = S_HELD;
               w_cnt_nx   = C_TERM;
               w_edge_nx  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         S_HELD:
            if (!i_in) begin
               w_state_nx = S_RELEASE_WAIT;
               w_cnt_nx   = '0;
            end
         S_RELEASE_WAIT:
            if (i_in) begin
               w_state_nx = S_HELD;
            end else if (r_cnt == C_LAST) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = C_TERM;
               w_edge_nx  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign o_level = (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);
   assign o_edge  = r_edge;
endmodule

module btn_event_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_DIV        = 1666666,
   parameter int REPEAT_TICKS    = 8
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic left_btn,
   input  logic right_btn,
   input  logic jump_btn,
   output logic tick,
   output logic left_level,
   output logic right_level,
   output logic jump_level,
   output logic left_evt,
   output logic right_evt,
   output logic jump_evt,
   output logic jump_rel_evt
);
   localparam int NB = 3;                         // 0 left, 1 right, 2 jump
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);

   logic [NB-1:0] r_sync1, r_sync2;
   logic [NB-1:0] w_level, w_edge, w_press;
   logic [TW-1:0] r_tick_cnt;
   logic          w_tick;
   logic [1:0]    w_move_set;                     // left/right pending set
   logic [3:0]    w_pset;                         // {jrel, jump, right, left}
   logic [3:0]    r_pend, r_evt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {jump_btn, right_btn, left_btn};
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .i_clk   (sys_clk),
         .i_rst_n (sys_rst_n),
         .i_in    (r_sync2[gi]),
         .o_level (w_level[gi]),
         .o_edge  (w_edge[gi])
      );
   end

   assign w_press = w_edge & w_level;
   assign w_tick  = (r_tick_cnt == C_TICK_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)  r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + TW'(1);
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [RW-1:0] C_REP_LAST = RW'(REPEAT_TICKS - 1);
   logic [1:0] w_rep;

   // Ticks are counted only while the level is held; dropping the level
   // restarts the repeat interval from the next press.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rep
      logic [RW-1:0] r_rep_cnt;
      assign w_rep[gi] = w_level[gi] && w_tick && (r_rep_cnt == C_REP_LAST);
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n)        r_rep_cnt <= '0;
         else if (!w_level[gi]) r_rep_cnt <= '0;
         else if (w_rep[gi])    r_rep_cnt <= '0;
         else if (w_tick)       r_rep_cnt <= r_rep_cnt + RW'(1);
      end
   end
   assign w_move_set = w_press[1:0] | w_rep;
`else
   assign w_move_set = w_press[1:0];
`endif

   assign w_pset = {w_edge[2] & ~w_level[2], w_press[2], w_move_set};

   // On tick the events take the pending flags; a pulse in the tick cycle
   // itself becomes pending for the next period. Left wins a left/right tie
   // and the right pending flag is dropped with it.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pend <= '0;
         r_evt  <= '0;
      end else if (w_tick) begin
         r_evt  <= {r_pend[3:2], r_pend[1] & ~r_pend[0], r_pend[0]};
         r_pend <= w_pset;
      end else begin
         r_pend <= r_pend | w_pset;
      end
   end

   assign tick         = w_tick;
   assign left_level   = w_level[0];
   assign right_level  = w_level[1];
   assign jump_level   = w_level[2];
   assign left_evt     = r_evt[0];
   assign right_evt    = r_evt[1];
   assign jump_evt     = r_evt[2];
   assign jump_rel_evt = r_evt[3];
endmodule

// File: doc/btn_event_conditioner.md
Name: btn_event_conditioner

Overview:
- Front-end stage feeding the character physics/FSM block.
- Synchronises and debounces the raw left/right/jump push-buttons on sys_clk.
- Generates the game-tick strobe that paces the character stage.
- Latches every debounced press/release edge into per-tick event flags, so a press shorter than one tick period is never lost by the slower character-update domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable sys_clk samples needed to accept a new button level (10 ms at 100 MHz); legal range >= 2.
- TICK_DIV, 1666666: sys_clk cycles per game tick (60 Hz at 100 MHz); legal range >= 2.
- REPEAT_TICKS, 8: ticks between auto-repeat events (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- left_btn  in  1  raw asynchronous button, active-high
- right_btn  in  1  raw asynchronous button, active-high
- jump_btn  in  1  raw asynchronous button, active-high
- tick  out  1  one-cycle strobe, once every TICK_DIV cycles
- left_level  out  1  debounced level
- right_level  out  1  debounced level
- jump_level  out  1  debounced level
- left_evt  out  1  left press occurred during the previous tick period
- right_evt  out  1  right press occurred during the previous tick period
- jump_evt  out  1  jump press occurred during the previous tick period
- jump_rel_evt  out  1  jump release occurred during the previous tick period

Behaviour:
- Reset (async assert, sync release): every output, synchroniser, counter and pending flag is 0; every debounce FSM is in IDLE.
- Synchroniser: each raw input passes through 2 flops before any use.
- Debounce FSM, one instance per button. States: IDLE (level 0), PRESS_WAIT, HELD (level 1), RELEASE_WAIT.
  - IDLE -> PRESS_WAIT when the synchronised input is 1; the counter clears.
  - PRESS_WAIT: counter increments while the input is 1; an input of 0 returns the FSM to IDLE (bounce rejected). When the counter reaches DEBOUNCE_CYCLES-1 with the input still 1, go to HELD, set level to 1, and emit an internal press pulse for 1 cycle.
  - HELD / RELEASE_WAIT: symmetric, producing a release pulse and level 0.
  - Timing: from the first stable synchronised sample to level change is exactly DEBOUNCE_CYCLES cycles. From the raw pin it is DEBOUNCE_CYCLES+2 cycles.
- Counter widths are $clog2(DEBOUNCE_CYCLES) and $clog2(TICK_DIV), both unsigned. The counters never exceed their terminal value and wrap to 0.
- Tick generator: the counter counts 0..TICK_DIV-1. tick=1 in the cycle the counter equals TICK_DIV-1. The first tick after reset is at cycle TICK_DIV-1.
- Event latching, per event type:
  - A pending flag is set by the internal pulse.
  - On a tick cycle, the matching *_evt register takes the pending flag, and the pending flag clears.
  - If a pulse arrives in the same cycle as tick, it sets pending for the next period and is not lost, and the current *_evt takes the old pending value.
  - *_evt is held constant for the whole tick period; it changes only in the cycle after tick.
  - Multiple presses in one period collapse into one event.
- Left/right conflict: if left_evt and right_evt would both load 1 at the same tick, only left_evt is set. right pending is dropped.
- Levels are not tick-aligned; they update immediately on debounce completion.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: while left_level or right_level stays 1, a per-button tick counter runs. Every REPEAT_TICKS ticks after the initial press it re-asserts the pending flag, so *_evt repeats. The counter resets when the level drops. Jump never repeats.
- Undefined: no repeat logic; exactly one *_evt per debounced press.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, TICK_DIV=10):
- Reset release, all buttons 0 for 40 cycles -> tick pulses at cycles 9, 19, 29, 39; all levels and events remain 0.
- left_btn held 1 from cycle 0 -> left_level rises at cycle 6; left_evt=1 from cycle 10 through 19, then 0 from cycle 20.
- jump_btn toggles 1,1,0,1,0 (bounce shorter than 4 stable cycles) -> jump_level and jump_evt stay 0.
- Debounced jump press completing in the same cycle as tick (cycle 19) -> jump_evt=0 during period 20-29; jump_evt=1 during period 30-39.
- left and right pressed simultaneously -> at the next tick left_evt=1, right_evt=0; after jump release completes, jump_rel_evt=1 for exactly one full period.
- sys_rst_n asserted mid-PRESS_WAIT with left_btn held -> all outputs 0 at once; after release, left_level is asserted no earlier than 6 cycles later.
